// File: rtl/rf_access_pkg.sv
// rf_access_pkg: response status codes and FSM state encoding for rf_access_ctrl
package rf_access_pkg;
    localparam logic [1:0] ST_OK         = 2'b00;
    localparam logic [1:0] ST_RF_INVALID = 2'b01;
    localparam logic [1:0] ST_TIMEOUT    = 2'b10;
    localparam logic [1:0] ST_RANGE      = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;
endpackage

// File: rtl/rf_access_timeout.sv
// rf_access_timeout: clear/enable cycle counter that flags the last permitted wait cycle
module rf_access_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic res,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (res || clear)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    // High during the TIMEOUT-th enabled cycle; the counter reaches TIMEOUT on that edge.
    assign expired = en && count == CW'(TIMEOUT - 1);
endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: single-outstanding host front end that strobes a register file,
// waits for completion under a timeout and returns data/status on a response channel.
module rf_access_ctrl #(
    parameter int HOST_AW = 16,
    parameter int RF_LSB  = 3,
    parameter int RF_MSB  = 4,
    parameter int DW      = 64,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [HOST_AW-1:0]       req_addr,
    input  logic [DW-1:0]            req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_rdata,
    output logic [1:0]               rsp_status,
    output logic [RF_MSB-RF_LSB:0]   address,
    output logic                     read_en,
    output logic                     write_en,
    output logic [DW-1:0]            write_data,
    input  logic [DW-1:0]            read_data,
    input  logic                     access_complete,
    input  logic                     invalid_address
);
    import rf_access_pkg::*;

    state_t        state, next;
    logic          wr;
    logic          expired;
    logic          out_of_range;
    logic          load_rsp;
    logic [1:0]    status_next;
    logic [DW-1:0] rdata_next;

    // Misaligned or beyond the RF window: answered locally without touching the RF.
    assign out_of_range = |req_addr[RF_LSB-1:0] || |req_addr[HOST_AW-1:RF_MSB+1];

    assign req_ready = state == S_IDLE;
    assign rsp_valid = state == S_RESP;
    assign read_en   = state == S_ISSUE && !wr;
    assign write_en  = state == S_ISSUE && wr;

    rf_access_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .res     (res),
        .clear   (state == S_RESP && rsp_ready),
        .en      (state == S_WAIT),
        .expired (expired)
    );

    always_comb begin
        next        = state;
        load_rsp    = 1'b0;
        status_next = ST_OK;
        rdata_next  = '0;
        case (state)
            S_IDLE: if (req_valid) begin
                next        = out_of_range ? S_RESP : S_ISSUE;
                load_rsp    = out_of_range;
                status_next = ST_RANGE;
            end
            S_ISSUE: next = S_WAIT;
            S_WAIT: if (access_complete || expired) begin
                next        = S_RESP;
                load_rsp    = 1'b1;
                status_next = !access_complete ? ST_TIMEOUT : invalid_address ? ST_RF_INVALID : ST_OK;
                rdata_next  = access_complete && !invalid_address && !wr ? read_data : '0;
            end
            S_RESP: if (rsp_ready) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= S_IDLE;
            wr         <= 1'b0;
            address    <= '0;
            write_data <= '0;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
        end else begin
            state <= next;
            if (req_valid && req_ready) begin
                wr         <= req_write;
                address    <= req_addr[RF_MSB:RF_LSB];
                write_data <= req_wdata;
            end
            if (load_rsp) begin
                rsp_rdata  <= rdata_next;
                rsp_status <= status_next;
            end
        end
    end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: vector table plus hand sequences against a stub RF with
// programmable completion delay; word 3 is unmapped, word 1 keeps 16 bits (node_id).
module tb_rf_access_ctrl;
    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [1:0]  address;
    logic        read_en;
    logic        write_en;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        access_complete;
    logic        invalid_address;

    int checks = 0;
    int errors = 0;

    rf_access_ctrl dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .address(address), .read_en(read_en), .write_en(write_en), .write_data(write_data),
        .read_data(read_data), .access_complete(access_complete), .invalid_address(invalid_address)
    );

    always #5 clk = ~clk;

    // Stub RF: completes rf_delay cycles after its strobe (0 = never)
    logic [63:0] mem [4];
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [1:0]  a = '0;
    int          rf_delay = 1;
    logic        spurious = 1'b0;

    assign access_complete = spurious || (pend && rf_delay != 0 && cnt == rf_delay);
    assign invalid_address = access_complete && a == 2'd3;
    assign read_data       = mem[a];

    always @(posedge clk) begin
        if (res) begin
            mem[0] <= 64'h0000_0000_0012_ABCD;
            mem[1] <= '0;
            mem[2] <= 64'hDEAD_BEEF_0BAD_F00D;
            mem[3] <= '0;
        end else if (write_en && address != 2'd3)
            mem[address] <= address == 2'd1 ? (write_data & 64'hFFFF) : write_data;
        if (read_en || write_en) begin
            pend <= 1'b1;
            cnt  <= 1;
            a    <= address;
        end else if (pend) begin
            if (access_complete) pend <= 1'b0;
            else cnt <= cnt + 1;
        end
    end

    int rd_total = 0;
    int wr_total = 0;
    always @(negedge clk) begin
        if (read_en) rd_total++;
        if (write_en) wr_total++;
    end

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [63:0] wdata;
        int          dly;
        logic [1:0]  st;
        logic [63:0] rd;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [63:0] rd;
        int          lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns cycles from handshake cycle to first rsp_valid.
    task automatic issue(input logic w, input logic [15:0] ad, input logic [63:0] d, input int dly, output int lat);
        rf_delay  = dly;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = ad;
        req_wdata = d;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        int   lat, r0, w0;
        exp_t e;
        sb.push_back('{v.st, v.rd, v.lat});
        r0 = rd_total;
        w0 = wr_total;
        issue(v.w, v.addr, v.wdata, v.dly, lat);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("status@%h", v.addr), 64'(rsp_status), 64'(e.st));
            chk($sformatf("rdata@%h", v.addr), rsp_rdata, e.rd);
            chk($sformatf("latency@%h", v.addr), 64'(lat), 64'(e.lat));
        end
        chk($sformatf("read_en_pulses@%h", v.addr), 64'(rd_total - r0), 64'(v.nrd));
        chk($sformatf("write_en_pulses@%h", v.addr), 64'(wr_total - w0), 64'(v.nwr));
        finish_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic bad;
        vecs[0]  = '{1'b1, 16'h0008, 64'h555A_AA55_5AAA_555A, 1,  2'b00, 64'h0,                    3,  0, 1};
        vecs[1]  = '{1'b0, 16'h0000, 64'h0,                   1,  2'b00, 64'h0000_0000_0012_ABCD, 3,  1, 0};
        vecs[2]  = '{1'b0, 16'h0008, 64'h0,                   1,  2'b00, 64'h0000_0000_0000_555A, 3,  1, 0};
        vecs[3]  = '{1'b0, 16'h0020, 64'h0,                   1,  2'b11, 64'h0,                    1,  0, 0};
        vecs[4]  = '{1'b1, 16'h0009, 64'h1234,                1,  2'b11, 64'h0,                    1,  0, 0};
        vecs[5]  = '{1'b0, 16'h0018, 64'h0,                   2,  2'b01, 64'h0,                    4,  1, 0};
        vecs[6]  = '{1'b0, 16'h0010, 64'h0,                   0,  2'b10, 64'h0,                    17, 1, 0};
        vecs[7]  = '{1'b0, 16'h0010, 64'h0,                   15, 2'b00, 64'hDEAD_BEEF_0BAD_F00D, 17, 1, 0};
        vecs[8]  = '{1'b0, 16'h0010, 64'h0,                   16, 2'b10, 64'h0,                    17, 1, 0};
        vecs[9]  = '{1'b1, 16'h0010, 64'h0123_4567_89AB_CDEF, 3,  2'b00, 64'h0,                    5,  0, 1};
        vecs[10] = '{1'b0, 16'h0010, 64'h0,                   1,  2'b00, 64'h0123_4567_89AB_CDEF, 3,  1, 0};
        vecs[11] = '{1'b0, 16'h8000, 64'h0,                   1,  2'b11, 64'h0,                    1,  0, 0};

        repeat (3) @(negedge clk);
        res = 1'b0;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_strobes", 64'({read_en, write_en}), 64'd0);
        chk("reset_rsp_status", 64'(rsp_status), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);

        for (int i = 0; i < 12; i++) do_txn(vecs[i]);

        // Response held back: everything stays put and no new request is taken.
        issue(1'b0, 16'h0000, 64'h0, 1, lat);
        chk("hold_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, 64'h0000_0000_0012_ABCD);
            chk("hold_status", 64'(rsp_status), 64'd0);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        finish_rsp();
        do_txn('{1'b0, 16'h0008, 64'h0, 1, 2'b00, 64'h0000_0000_0000_555A, 3, 1, 0});

        // Reset while waiting on the RF, then a late and a spurious completion.
        rf_delay  = 5;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0008;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_in_wait", 64'({rsp_valid, req_ready}), 64'd0);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk("midreset_req_ready", 64'(req_ready), 64'd1);
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset_strobes", 64'({read_en, write_en}), 64'd0);
        chk("midreset_address", 64'(address), 64'd0);
        chk("midreset_write_data", write_data, 64'd0);
        chk("midreset_rsp_rdata", rsp_rdata, 64'd0);
        chk("midreset_rsp_status", 64'(rsp_status), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spurious = i == 6 || i == 7;
            @(negedge clk);
            bad |= rsp_valid | read_en | write_en | !req_ready;
        end
        spurious = 1'b0;
        chk("late_complete_ignored", 64'(bad), 64'd0);
        do_txn('{1'b0, 16'h0000, 64'h0, 1, 2'b00, 64'h0000_0000_0012_ABCD, 3, 1, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
